// File: rtl/subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor and its flag consumers.
package subtractor_pkg;

    // Controller states: wait for a request, process one bit per cycle, announce completion.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit positions inside the 4-bit {N, V, C, Z} flag vector used across the ALU.
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;
    localparam int FLAG_W = 4;

    // Assemble a flag vector from named condition bits so callers never hard-code positions.
    function automatic logic [FLAG_W-1:0] pack_flags(
        input logic z,
        input logic c,
        input logic v,
        input logic n
    );
        logic [FLAG_W-1:0] f;
        f         = '0;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_N] = n;
        return f;
    endfunction

endpackage

// File: rtl/one_bit_full_subtractor.sv
// Single full-subtractor cell: d = a - b - bin, with borrow out.
module one_bit_full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference is the parity of the three inputs.
    assign d    = a ^ b ^ bin;
    // Borrow out when b exceeds a, or when they are equal and a borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/n_bit_serial_subtractor.sv
// Bit-serial N-bit subtractor: computes a - b LSB first through one shared
// full-subtractor cell, with a start/busy/done handshake and ALU-style flags.
module n_bit_serial_subtractor
    import subtractor_pkg::*;
#(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N-1:0]      a,
    input  logic [N-1:0]      b,
    output logic              busy,
    output logic              done,
    output logic [N-1:0]      result,
    output logic [FLAG_W-1:0] flags
);

    localparam int            CW       = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    state_t            state;
    logic [N-1:0]      a_sh;
    logic [N-1:0]      b_sh;
    logic [N-1:0]      diff;
    logic              borrow;
    logic [CW-1:0]     cnt;
    // MSBs of the captured operands; the shift registers lose them before V is computed.
    logic              a_msb;
    logic              b_msb;

    logic              d_bit;
    logic              bout;
    logic [N-1:0]      diff_next;
    logic [FLAG_W-1:0] flags_next;

    one_bit_full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow),
        .d    (d_bit),
        .bout (bout)
    );

    // Completed difference and flags as they will look after the current SHIFT edge.
    always_comb begin
        diff_next  = {d_bit, diff[N-1:1]};
        flags_next = pack_flags(
            (diff_next == '0),
            bout,
            (a_msb ^ b_msb) & (a_msb ^ d_bit),
            d_bit
        );
    end

    // Controller FSM with datapath registers and registered handshake/result outputs.
    // NOTE: every register here uses <= so all of them see pre-edge values of each other;
    // the cell outputs and diff_next are therefore the values for the bit being consumed.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: all state, including the datapath, is reset so an aborted operation
        // leaves nothing behind that could leak into the next one.
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            diff   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            flags  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        a_msb  <= a[N-1];
                        b_msb  <= b[N-1];
                        borrow <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    diff   <= diff_next;
                    a_sh   <= {1'b0, a_sh[N-1:1]};
                    b_sh   <= {1'b0, b_sh[N-1:1]};
                    borrow <= bout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        result <= diff_next;
                        flags  <= flags_next;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_n_bit_serial_subtractor.sv
// Scoreboard bench for n_bit_serial_subtractor: stimulus pushes expected results,
// a negedge monitor pops and compares whenever done is seen.
module tb_n_bit_serial_subtractor;

    localparam int N = 4;

    typedef struct {
        logic [N-1:0] res;
        logic [3:0]   flg;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic [3:0]   flags;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb[$];

    n_bit_serial_subtractor #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flags  (flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain modular and signed arithmetic on the operand values.
    function automatic exp_t ref_sub(input logic [N-1:0] x, input logic [N-1:0] y);
        exp_t e;
        int ux, uy, sx, sy, ud, sd;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= (1 << (N - 1))) ? ux - (1 << N) : ux;
        sy = (uy >= (1 << (N - 1))) ? uy - (1 << N) : uy;
        ud = (ux - uy + (1 << N)) % (1 << N);
        sd = sx - sy;
        e.res    = ud[N-1:0];
        e.flg[0] = (ud == 0);
        e.flg[1] = (ux < uy);
        e.flg[2] = (sd > (1 << (N - 1)) - 1) || (sd < -(1 << (N - 1)));
        e.flg[3] = ud[N-1];
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: done=1 with no operation outstanding (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("flags", 32'(flags), 32'(e.flg));
            end
        end
    end

    // One operation; optionally pokes start during SHIFT and DONE to prove it is ignored.
    task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                         input exp_t e, input bit poke);
        int cycles;
        int busy_cnt;
        @(negedge clk);
        a = ta;
        b = tb_v;
        start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = N'($urandom);
        b = N'($urandom);
        cycles = 0;
        busy_cnt = 0;
        while (!done && cycles < 20) begin
            if (busy) busy_cnt++;
            start = poke && (cycles == 2);
            if (start) begin
                a = N'($urandom);
                b = N'($urandom);
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        check("latency", 32'(cycles), 32'(N));
        check("busy_len", 32'(busy_cnt), 32'(N));
        check("busy_at_done", 32'(busy), 32'd0);
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        check("result_held", 32'(result), 32'(e.res));
        check("flags_held", 32'(flags), 32'(e.flg));
    endtask

    task automatic wait_done(output int t);
        t = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                t = cyc;
                break;
            end
        end
        check("wait_done_timeout", 32'(t >= 0), 32'd1);
    endtask

    initial begin
        exp_t e;
        int t1, t2;

        // Reset state.
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed vectors with hand-derived expectations.
        e.res = 4'b0100; e.flg = 4'b0000; do_op(4'b0111, 4'b0011, e, 1'b0);
        e.res = 4'b0000; e.flg = 4'b0001; do_op(4'b0101, 4'b0101, e, 1'b0);
        e.res = 4'b1110; e.flg = 4'b1010; do_op(4'b0011, 4'b0101, e, 1'b0);
        e.res = 4'b0111; e.flg = 4'b0100; do_op(4'b1000, 4'b0001, e, 1'b0);

        // Start pokes during SHIFT and DONE must not create extra operations.
        e.res = 4'b1101; e.flg = 4'b1010; do_op(4'b0010, 4'b0101, e, 1'b1);
        repeat (8) @(negedge clk);

        // Abort mid-SHIFT: outputs clear asynchronously, no completion follows.
        @(negedge clk);
        a = 4'b1111;
        b = 4'b0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_flags", 32'(flags), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Held start: back-to-back completions N+2 cycles apart.
        a = 4'b1111;
        b = 4'b0001;
        start = 1'b1;
        e.res = 4'b1110; e.flg = 4'b1000;
        sb.push_back(e);
        sb.push_back(e);
        wait_done(t1);
        wait_done(t2);
        start = 1'b0;
        check("b2b_spacing", 32'(t2 - t1), 32'(N + 2));
        repeat (8) @(negedge clk);

        // Randomized operations against the arithmetic reference.
        for (int i = 0; i < 24; i++) begin
            logic [N-1:0] ra, rb;
            ra = N'($urandom);
            rb = N'($urandom);
            do_op(ra, rb, ref_sub(ra, rb), bit'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/n_bit_serial_subtractor.md
# n_bit_serial_subtractor

Bit-serial N-bit subtractor computing a − b one bit per clock, LSB first, with a start/busy/done handshake. It is the inverse-operation counterpart to the ripple adder in the arithmetic datapath. It trades N full-subtractor cells for a single shared cell plus control, and reports the same 4-bit flag vector used elsewhere in the ALU. It sits beside the adder behind the operation mux and is driven by the lab FSM or by switches through a start pulse.

## Interface
- N, default 4: operand and result width; legal range N ≥ 2.
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  N  minuend; captured on the accepting edge.
- b  input  N  subtrahend; captured on the accepting edge.
- busy  output  1  high while an operation is in progress (SHIFT state).
- done  output  1  one-cycle pulse; result/flags are valid from this cycle onward.
- result  output  N  a − b modulo 2^N; held until the next completion.
- flags  output  4  {N, V, C, Z} = bits [3:0]:
  - Z (bit 0): result is zero.
  - C (bit 1): final borrow, 1 when a < b unsigned.
  - V (bit 2): signed overflow.
  - N (bit 3): result MSB.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - Latch a and b into shift registers; clear borrow and bit counter.
  - Go to SHIFT.
- IDLE, start=0: stay.
- SHIFT, each cycle, on bit i = LSBs of the operand shift registers:
  - d = a_i ^ b_i ^ borrow.
  - borrow_next = (~a_i & b_i) | (~(a_i ^ b_i) & borrow).
  - Shift d into the internal difference register from the MSB end.
  - Shift the operands right; increment the counter.
- After N SHIFT cycles, go to DONE. On that edge, load result and flags from the completed difference and final borrow:
  - Z = (diff == 0).
  - C = final borrow.
  - N = diff[N-1].
  - V = (a[N-1] ^ b[N-1]) & (a[N-1] ^ diff[N-1]), using the latched a and b.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- start is ignored in SHIFT and DONE; a held start is accepted on the first IDLE edge.
- The outputs result and flags change only on entry to DONE. The internal diff register never drives the outputs directly.
- Reset (asynchronous, any state):
  - State goes to IDLE; busy=0, done=0, result=0, flags=0.
  - The counter, borrow, and shift registers are cleared.
  - An in-flight operation is discarded and never completes.

## Timing
- Let edge 0 be the edge that samples start=1 in IDLE.
- busy is high from after edge 0 until edge N.
- done is high between edges N and N+1; result and flags update at edge N.
- Latency from start to done is N cycles. Back-to-back throughput is one operation per N+2 cycles when start is held high (IDLE re-entry at edge N+1, acceptance at edge N+2).
- a and b may change freely after edge 0.
- Counter width is $clog2(N)+1. The terminal count is N−1 on the last SHIFT edge; there is no wrap-around inside an operation.

## Structure
- Package subtractor_pkg holds:
  - the state enum typedef (IDLE, SHIFT, DONE);
  - flag index constants FLAG_Z=0, FLAG_C=1, FLAG_V=2, FLAG_N=3, shared with the adder's flag consumers.
- Sub-module one_bit_full_subtractor: combinational (a, b, bin) -> (d, bout), instanced once.
- The top module contains the FSM, counter, shift registers, and output registers.

## Test plan
All scenarios use N=4.
- a=0111, b=0011, start pulse -> done at edge 4, result=0100, flags=0000; busy high for exactly 4 cycles.
- a=0101, b=0101 -> result=0000, flags=0001 (Z).
- a=0011, b=0101 -> result=1110, flags=1010 (N, C).
- a=1000, b=0001 -> result=0111, flags=0100 (V only).
- Start pulses during SHIFT and DONE are ignored. Assert rst mid-SHIFT at cycle 2 -> busy, done, result, flags all 0 immediately without waiting for a clock; no done ever pulses for the aborted operation.
- Hold start high with a=1111, b=0001 -> two completions with done exactly 6 cycles apart, result=1110, flags=1000 each time.
